mux_uart_rx: RTL and testbench

MUX_UART_RX -- requirements
Module: mux_uart_rx

---
 rtl/mux_uart_rx.sv | 193 +++++++++++++++++++
 tb/tb_mux_uart_rx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_uart_rx.sv
// Memory-mapped 8N1 UART receiver with a small receive FIFO, status/data
// registers on the CPU bus and an active-low "receive data available" interrupt.
module mux_uart_rx #(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [18:0] BASE_ADDR    = 19'h3f200
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [18:0] address,
    input  logic        write_en,
    input  logic [7:0]  data_in,
    input  logic        read_strobe,
    input  logic        rx,
    output logic [7:0]  data_out,
    output logic        selected,
    output logic        int_reqn
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_F = PTR_W + 1;

    localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_F-1:0] DEPTH_C   = CNT_F'(FIFO_DEPTH);
    localparam logic [18:0]      DATA_ADDR = BASE_ADDR + 19'd1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q, rx_prev_q;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_F-1:0] count_q, count_d;

    logic ovr_q, ovr_d, ferr_q, ferr_d, ie_q, ie_d;
    logic int_reqn_q, int_reqn_d;

    logic rx_s, push, ferr_set, ovr_set, pop, do_write, wr_status;
    logic fifo_empty, fifo_full;
    logic unused_data_in;

    assign rx_s           = sync2_q;
    assign fifo_empty     = (count_q == '0);
    assign fifo_full      = (count_q == DEPTH_C);
    assign unused_data_in = ^data_in[5:0];

    // Receiver FSM: all sample points are counted from the detected falling edge.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        push      = 1'b0;
        ferr_set  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    state_d   = START;
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                end
            end
            START: begin
                if (clk_cnt_q == HALF_M1) begin
                    clk_cnt_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (clk_cnt_q == FULL_M1) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (clk_cnt_q == FULL_M1) begin
                    clk_cnt_d = '0;
                    if (rx_s) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = WAIT_HIGH;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO and control registers; a pop frees the slot a same-cycle push needs.
    always_comb begin
        pop       = read_strobe && (address == DATA_ADDR) && !fifo_empty;
        ovr_set   = push && fifo_full && !pop;
        do_write  = push && !ovr_set;
        wr_status = write_en && (address == BASE_ADDR);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_write) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + CNT_F'(do_write) - CNT_F'(pop);

        ie_d   = wr_status ? data_in[7] : ie_q;
        ovr_d  = ovr_q;
        ferr_d = ferr_q;
        if (wr_status && data_in[6]) begin
            ovr_d  = 1'b0;
            ferr_d = 1'b0;
        end
        if (ovr_set)  ovr_d  = 1'b1;
        if (ferr_set) ferr_d = 1'b1;

        int_reqn_d = ~(ie_q & ~fifo_empty);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            state_q    <= IDLE;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
            ie_q       <= 1'b0;
            int_reqn_q <= 1'b1;
        end else begin
            sync1_q    <= rx;
            sync2_q    <= sync1_q;
            rx_prev_q  <= sync2_q;
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
            ie_q       <= ie_d;
            int_reqn_q <= int_reqn_d;
        end
    end

    always_comb begin
        selected = (address == BASE_ADDR) || (address == DATA_ADDR);
        data_out = 8'h00;
        if (address == BASE_ADDR) begin
            data_out = {ie_q, 2'b00, fifo_full, ferr_q, ovr_q, 1'b1, ~fifo_empty};
        end else if (address == DATA_ADDR && !fifo_empty) begin
            data_out = mem_q[rd_ptr_q];
        end
    end

    assign int_reqn = int_reqn_q;

endmodule

// File: tb/tb_mux_uart_rx.sv
// Directed bench for mux_uart_rx at CLKS_PER_BIT=16, FIFO_DEPTH=4.
module tb_mux_uart_rx;

    localparam logic [18:0] BASE = 19'h3f200;
    localparam logic [18:0] DATA = 19'h3f201;

    logic        clock = 1'b0;
    logic        reset;
    logic [18:0] address;
    logic        write_en;
    logic [7:0]  data_in;
    logic        read_strobe;
    logic        rx;
    logic [7:0]  data_out;
    logic        selected;
    logic        int_reqn;

    int checks = 0;
    int errors = 0;

    mux_uart_rx #(
        .CLKS_PER_BIT(16),
        .FIFO_DEPTH  (4),
        .BASE_ADDR   (BASE)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .address    (address),
        .write_en   (write_en),
        .data_in    (data_in),
        .read_strobe(read_strobe),
        .rx         (rx),
        .data_out   (data_out),
        .selected   (selected),
        .int_reqn   (int_reqn)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic [7:0] exp);
        address = BASE;
        #1;
        checkOutput(tag, data_out, exp);
    endtask

    task automatic read_data(input string tag, input logic [7:0] exp);
        address = DATA;
        #1;
        checkOutput(tag, data_out, exp);
        read_strobe = 1'b1;
        tick(1);
        read_strobe = 1'b0;
    endtask

    task automatic cpu_write(input logic [18:0] addr, input logic [7:0] value);
        address  = addr;
        data_in  = value;
        write_en = 1'b1;
        tick(1);
        write_en = 1'b0;
    endtask

    // Start bit plus eight data bits; the caller drives the stop bit.
    task automatic start_frame(input logic [7:0] b);
        rx = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(16);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        start_frame(b);
        rx = 1'b1;
        tick(16);
        tick(4);
    endtask

    initial begin
        logic found;
        reset       = 1'b1;
        address     = BASE;
        write_en    = 1'b0;
        data_in     = 8'h00;
        read_strobe = 1'b0;
        rx          = 1'b1;
        tick(3);

        check_status("reset_status", 8'h02);
        checkOutput("reset_int_reqn", {7'b0, int_reqn}, 8'h01);
        checkOutput("sel_base", {7'b0, selected}, 8'h01);
        address = DATA;
        #1;
        checkOutput("sel_data", {7'b0, selected}, 8'h01);
        checkOutput("reset_data_empty", data_out, 8'h00);
        address = BASE + 19'd2;
        #1;
        checkOutput("sel_above", {7'b0, selected}, 8'h00);
        checkOutput("unsel_data_out", data_out, 8'h00);
        address = BASE - 19'd1;
        #1;
        checkOutput("sel_below", {7'b0, selected}, 8'h00);
        reset = 1'b0;
        tick(4);

        applyStimulus(8'h41);
        check_status("rx41_status", 8'h03);
        read_data("rx41_data", 8'h41);
        check_status("rx41_after_read", 8'h02);

        for (int i = 1; i <= 5; i++) applyStimulus(8'(i));
        check_status("ovr_status", 8'h17);
        read_data("ovr_rd1", 8'h01);
        read_data("ovr_rd2", 8'h02);
        read_data("ovr_rd3", 8'h03);
        read_data("ovr_rd4", 8'h04);
        read_data("ovr_rd_empty", 8'h00);
        check_status("ovr_after_drain", 8'h06);
        cpu_write(BASE, 8'h40);
        check_status("ovr_cleared", 8'h02);

        start_frame(8'h55);
        rx = 1'b0;
        tick(16);
        rx = 1'b1;
        tick(8);
        check_status("ferr_status", 8'h0A);
        cpu_write(DATA, 8'hC0);
        check_status("data_write_ignored", 8'h0A);
        cpu_write(BASE, 8'h40);
        check_status("ferr_cleared", 8'h02);

        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(30);
        check_status("glitch_status", 8'h02);
        applyStimulus(8'h3C);
        read_data("after_glitch_data", 8'h3C);

        cpu_write(BASE, 8'h80);
        start_frame(8'h7E);
        rx = 1'b1;
        address = BASE;
        #1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (data_out[0]) found = 1'b1;
            else tick(1);
        end
        checkOutput("int_push_seen", {7'b0, found}, 8'h01);
        checkOutput("int_at_push", {7'b0, int_reqn}, 8'h01);
        tick(1);
        checkOutput("int_after_push", {7'b0, int_reqn}, 8'h00);
        tick(20);
        read_data("int_data", 8'h7E);
        checkOutput("int_at_pop", {7'b0, int_reqn}, 8'h00);
        tick(1);
        checkOutput("int_after_pop", {7'b0, int_reqn}, 8'h01);
        cpu_write(BASE, 8'h00);

        for (int i = 0; i < 4; i++) applyStimulus(8'h11 + 8'(i));
        check_status("full_status", 8'h13);
        start_frame(8'h15);
        rx = 1'b1;
        tick(10);
        address     = DATA;
        read_strobe = 1'b1;
        tick(1);
        read_strobe = 1'b0;
        tick(8);
        check_status("pushpop_full_status", 8'h13);
        read_data("pushpop_rd1", 8'h12);
        read_data("pushpop_rd2", 8'h13);
        read_data("pushpop_rd3", 8'h14);
        read_data("pushpop_rd4", 8'h15);
        check_status("pushpop_drained", 8'h02);

        rx = 1'b0;
        tick(50);
        reset = 1'b1;
        tick(1);
        check_status("midframe_reset_status", 8'h02);
        checkOutput("midframe_reset_int", {7'b0, int_reqn}, 8'h01);
        rx = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(4);
        applyStimulus(8'hA5);
        check_status("post_reset_status", 8'h03);
        read_data("post_reset_data", 8'hA5);
        check_status("post_reset_empty", 8'h02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
